// File: rtl/seq_shifter_pkg.sv
// Shared definitions for the sequential shifter: operation codes and FSM states.
// Codes 000 and 100 both mean hold; only 000 gets a name.
package seq_shifter_pkg;

  localparam int COD_W = 3;

  typedef logic [COD_W-1:0] cod_t;

  localparam cod_t NO  = 3'b000;
  localparam cod_t DLD = 3'b001;
  localparam cod_t DLI = 3'b010;
  localparam cod_t RD  = 3'b011;
  localparam cod_t DAD = 3'b101;
  localparam cod_t DAI = 3'b110;
  localparam cod_t RI  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Request/result bundle between a requester (master) and the shifter (slave).
interface seq_shifter_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
);
  import seq_shifter_pkg::*;

  logic             start;
  logic [WIDTH-1:0] E;
  cod_t             cod;
  logic [AMT_W-1:0] amt;
  logic [WIDTH-1:0] S;
  logic             busy;
  logic             done;

  modport master (output start, E, cod, amt, input S, busy, done);
  modport slave  (input start, E, cod, amt, output S, busy, done);

endinterface

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-position shift; the only place operation codes are interpreted.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_data,
  input  cod_t             i_cod,
  output logic [WIDTH-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_cod)
      DLD:     o_data = {1'b0, i_data[WIDTH-1:1]};
      DLI:     o_data = {i_data[WIDTH-2:0], 1'b0};
      RD:      o_data = {i_data[0], i_data[WIDTH-1:1]};
      DAD:     o_data = {i_data[WIDTH-1], i_data[WIDTH-1:1]};
      // Sign bit is pinned; only the magnitude bits move left.
      DAI:     o_data = {i_data[WIDTH-1], i_data[WIDTH-3:0], 1'b0};
      RI:      o_data = {i_data[WIDTH-2:0], i_data[WIDTH-1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Sequential shifter: captures an operand and applies amt single-position steps,
// one per clock, then pulses done for one cycle.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_shifter_if.slave bus
);

  state_t           r_state;
  logic [AMT_W-1:0] r_cnt;
  cod_t             r_cod;
  logic [WIDTH-1:0] r_s;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] w_step;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_data (r_s),
    .i_cod  (r_cod),
    .o_data (w_step)
  );

  // busy/done are registered alongside the state so they change exactly with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cod   <= NO;
      r_s     <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_s    <= bus.E;
            r_cod  <= bus.cod;
            r_cnt  <= bus.amt;
            r_busy <= 1'b1;
            if (bus.amt != '0) begin
              r_state <= ST_SHIFT;
            end else begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          r_s   <= w_step;
          r_cnt <= r_cnt - AMT_W'(1);
          if (r_cnt == AMT_W'(1)) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.S    = r_s;
  assign bus.busy = r_busy;
  assign bus.done = r_done;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed and randomized checks of seq_shifter against an arithmetic reference model.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  localparam int WIDTH = 4;
  localparam int AMT_W = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_shifter_if #(.WIDTH(WIDTH), .AMT_W(AMT_W)) busIf ();

  seq_shifter #(.WIDTH(WIDTH), .AMT_W(AMT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  always #5 clk = ~clk;

  // Whole-operation result computed directly from the shift amount.
  function automatic logic [WIDTH-1:0] refModel(input logic [WIDTH-1:0] e,
                                                input logic [2:0] c, input int n);
    logic [WIDTH-1:0] r;
    r = e;
    case (c)
      3'b001: r = e >> n;
      3'b010: r = e << n;
      3'b011: r = (n == 0) ? e : ((e >> n) | (e << (WIDTH - n)));
      3'b101: r = $signed(e) >>> n;
      3'b110: r = {e[WIDTH-1], e[WIDTH-2:0] << n};
      3'b111: r = (n == 0) ? e : ((e << n) | (e >> (WIDTH - n)));
      default: r = e;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge while idle; returns at the negedge of the first idle cycle after done.
  task automatic applyStimulus(input logic [WIDTH-1:0] e, input logic [2:0] c,
                               input int a, input bit pokeBusy);
    logic [WIDTH-1:0] expS;
    int cycles;
    bit seen;
    expS = refModel(e, c, a);
    busIf.start = 1'b1;
    busIf.E     = e;
    busIf.cod   = c;
    busIf.amt   = AMT_W'(a);
    @(negedge clk);
    busIf.start = 1'b0;
    busIf.E     = WIDTH'($urandom);
    busIf.cod   = 3'($urandom);
    busIf.amt   = AMT_W'($urandom);
    cycles = 1;
    seen   = 1'b0;
    while (!seen && cycles <= WIDTH + 2) begin
      if (busIf.done) begin
        seen = 1'b1;
      end else begin
        busIf.start = pokeBusy && (cycles == 1);
        @(negedge clk);
        cycles++;
      end
    end
    busIf.start = 1'b0;
    checkOutput("doneSeen", 32'(seen), 32'd1);
    checkOutput("doneLatency", 32'(cycles), 32'(a + 1));
    checkOutput("result", 32'(busIf.S), 32'(expS));
    checkOutput("busyAtDone", 32'(busIf.busy), 32'd1);
    @(negedge clk);
    checkOutput("donePulseWidth", 32'(busIf.done), 32'd0);
    checkOutput("idleBusy", 32'(busIf.busy), 32'd0);
    checkOutput("retainResult", 32'(busIf.S), 32'(expS));
  endtask

  initial begin
    busIf.start = 1'b0;
    busIf.E     = '0;
    busIf.cod   = NO;
    busIf.amt   = '0;
    #1 rst_n = 1'b0;
    #2;
    checkOutput("resetS", 32'(busIf.S), 32'd0);
    checkOutput("resetBusy", 32'(busIf.busy), 32'd0);
    checkOutput("resetDone", 32'(busIf.done), 32'd0);
    busIf.start = 1'b1;
    busIf.E     = 4'b1111;
    busIf.amt   = 2'd2;
    repeat (2) @(negedge clk);
    checkOutput("resetHoldS", 32'(busIf.S), 32'd0);
    checkOutput("resetHoldBusy", 32'(busIf.busy), 32'd0);
    busIf.start = 1'b0;
    rst_n = 1'b1;

    $display("[TB] directed scenarios");
    applyStimulus(4'b1011, 3'b011, 2, 1'b0);
    applyStimulus(4'b1000, 3'b101, 3, 1'b0);
    applyStimulus(4'b0011, 3'b110, 1, 1'b0);
    applyStimulus(4'b1011, 3'b110, 2, 1'b0);
    applyStimulus(4'b0101, 3'b001, 0, 1'b0);
    applyStimulus(4'b1001, 3'b100, 3, 1'b0);
    applyStimulus(4'b0110, 3'b111, 3, 1'b1);
    applyStimulus(4'b1101, 3'b010, 1, 1'b1);
    checkOutput("knownRotR", 32'(refModel(4'b1011, 3'b011, 2)), 32'hE);

    $display("[TB] reset mid-operation");
    busIf.start = 1'b1;
    busIf.E     = 4'b1011;
    busIf.cod   = DLD;
    busIf.amt   = 2'd3;
    @(negedge clk);
    busIf.start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abortS", 32'(busIf.S), 32'd0);
    checkOutput("abortBusy", 32'(busIf.busy), 32'd0);
    checkOutput("abortDone", 32'(busIf.done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("abortNoDone", 32'(busIf.done), 32'd0);
    end
    rst_n = 1'b1;
    applyStimulus(4'b1010, 3'b001, 2, 1'b0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(WIDTH'($urandom), 3'($urandom), $urandom_range(0, WIDTH - 1),
                    1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
